mem_seq_ctrl: RTL

Sequencer and arbiter for the core's single-ported, byte-wide data/instruction memory. It takes word fetches from the fetch stage and sized loads/stores from the execute stage, using the same size encoding as the control unit's memory-offset field. It serialises each request into per-byte memory cycles, assembles little-endian read data with sign/zero extension, and returns a one-cycle done pulse. The core stalls on `busy`.

---
 rtl/mem_seq_ctrl_pkg.sv | 27 ++
 rtl/mem_seq_ctrl_load_extend.sv | 20 ++
 rtl/mem_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_seq_ctrl_pkg.sv
// Shared encodings for the memory sequencer: size codes, FSM states, port selects.
package mem_seq_ctrl_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Byte count for a size code; 0 marks an unsupported size.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load word by access size.
module load_extend
  import mem_seq_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  size,
  input  logic        zero_ext,
  output logic [31:0] ext
);

  // Replicate the top bit of the accessed width unless zero extension is requested.
  always_comb begin
    case (size)
      SZ_BYTE: ext = {{24{~zero_ext & word[7]}}, word[7:0]};
      SZ_HALF: ext = {{16{~zero_ext & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Arbitrates fetch and data requests onto a byte-wide single-port memory,
// serialising each access into byte cycles and assembling load data.
module mem_seq_ctrl
  import mem_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        n;
  logic              port;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [2:0]        size_l;
  logic              uns_l;
  logic [31:0]       asm_word;
  logic [31:0]       next_asm;
  logic [31:0]       ext_word;
  logic              grant_d;
  logic              grant_if;
  logic              last_cycle;
  logic              unused_addr_hi;

  // Address bits above the memory width are intentionally discarded.
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

  assign grant_d    = (state == IDLE) && d_req;
  assign grant_if   = (state == IDLE) && !d_req && if_req;
  assign busy       = (state != IDLE);
  // Stores finish on their last issued byte; loads need one extra cycle for the final read byte.
  assign last_cycle = we ? (cnt == n - 3'd1) : (cnt == n);

  // Merge the byte returning from the previous cycle's address into the assembly word.
  always_comb begin
    next_asm = asm_word;
    case (cnt)
      3'd1:    next_asm[7:0]   = mem_rdata;
      3'd2:    next_asm[15:8]  = mem_rdata;
      3'd3:    next_asm[23:16] = mem_rdata;
      3'd4:    next_asm[31:24] = mem_rdata;
      default: next_asm = asm_word;
    endcase
  end

  load_extend u_load_extend (
    .word     (next_asm),
    .size     (size_l),
    .zero_ext (uns_l),
    .ext      (ext_word)
  );

  // Drive the memory port from state and latched fields; quiet outside active byte cycles.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (state == ACCESS && cnt < n) begin
      mem_addr = base + ADDR_W'(cnt);
      mem_we   = we;
      if (we) begin
        case (cnt[1:0])
          2'd0:    mem_wdata = wdata[7:0];
          2'd1:    mem_wdata = wdata[15:8];
          2'd2:    mem_wdata = wdata[23:16];
          default: mem_wdata = wdata[31:24];
        endcase
      end
    end
  end

  // Request datapath latches; no reset needed since they are reloaded on every grant.
  always_ff @(posedge clk) begin
    if (grant_d) begin
      base     <= d_addr[ADDR_W-1:0];
      wdata    <= d_wdata;
      size_l   <= d_size;
      uns_l    <= d_unsigned;
      asm_word <= '0;
    end else if (grant_if) begin
      base     <= if_addr[ADDR_W-1:0];
      wdata    <= '0;
      size_l   <= SZ_WORD;
      uns_l    <= 1'b0;
      asm_word <= '0;
    end else if (state == ACCESS && !we && cnt != 3'd0) begin
      asm_word <= next_asm;
    end
  end

  // Sequencer FSM with registered done pulses and read-data return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      n        <= 3'd0;
      port     <= PORT_IF;
      we       <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (grant_d) begin
            port <= PORT_D;
            we   <= d_we;
            n    <= size_bytes(d_size);
            if (size_bytes(d_size) == 3'd0) begin
              state   <= DONE;
              d_done  <= 1'b1;
              d_rdata <= '0;
            end else begin
              state <= ACCESS;
            end
          end else if (grant_if) begin
            port  <= PORT_IF;
            we    <= 1'b0;
            n     <= 3'd4;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 3'd1;
          if (last_cycle) begin
            state <= DONE;
            if (port == PORT_D) begin
              d_done <= 1'b1;
              if (!we) d_rdata <= ext_word;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ext_word;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
